// File: rtl/follow_pkg.sv
// Shared types and timing constants for the line-follower travel controller.
package follow_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FOLLOW = 2'b01,
    ST_LOST   = 2'b10,
    ST_FAULT  = 2'b11
  } state_t;

  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_GO   = 2'b01;

  localparam logic [15:0] LOST_CYC_FAST = 16'd512;
  localparam logic [15:0] LOST_CYC_SLOW = 16'd50000;
  localparam logic [15:0] BUZZ_DIV_FAST = 16'd64;
  localparam logic [15:0] BUZZ_DIV_SLOW = 16'd12500;

  function automatic logic [15:0] lost_cyc_f(input logic fast);
    return fast ? LOST_CYC_FAST : LOST_CYC_SLOW;
  endfunction

  function automatic logic [15:0] buzz_div_f(input logic fast);
    return fast ? BUZZ_DIV_FAST : BUZZ_DIV_SLOW;
  endfunction

endpackage

// File: rtl/follow_timer.sv
// 16-bit up-counter with clear, enable, saturation and a terminal-count flag.
module follow_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] term,
  output logic        tc
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: clear wins, increments stop at all-ones so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 16'd0;
    end else if (en && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == term);

endmodule

// File: rtl/follow_ctrl.sv
// Travel controller: accepts GO/STOP commands, follows the line to a destination
// station, tolerates short line loss and raises a buzzing fault on long loss or stall.
module follow_ctrl
  import follow_pkg::*;
#(
  parameter bit FAST_SIM = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cmd,
  input  logic       cmd_rdy,
  output logic       clr_cmd_rdy,
  input  logic [7:0] ID,
  input  logic       ID_vld,
  output logic       clr_ID_vld,
  input  logic       line_present,
  input  logic       moving,
  output logic       go,
  output logic       in_transit,
  output logic       buzz
);

  localparam logic [15:0] LOST_CYC = lost_cyc_f(FAST_SIM);
  localparam logic [15:0] BUZZ_DIV = buzz_div_f(FAST_SIM);

  state_t      state_q, state_d;
  logic [5:0]  dest_q, dest_d;
  logic        go_q, go_d;
  logic        in_transit_q, in_transit_d;
  logic        buzz_q, buzz_d;

  logic        cmd_go, cmd_stop, id_hit;
  logic        lost_clr, lost_en, lost_tc;
  logic [15:0] lost_term;
  logic        buzz_clr, buzz_en, buzz_tc;
  logic        unused_id_bits;

  assign unused_id_bits = ^ID[7:6];

  assign clr_cmd_rdy = rst_n & cmd_rdy;
  assign clr_ID_vld  = rst_n & ID_vld;

  assign cmd_go   = cmd_rdy && (cmd[7:6] == OP_GO);
  assign cmd_stop = cmd_rdy && (cmd[7:6] == OP_STOP);
  assign id_hit   = ID_vld && (ID[5:0] == dest_q);

  // In LOST the first missing-line sample was taken in FOLLOW, hence the shorter terminal.
  assign lost_term = (state_q == ST_LOST) ? (LOST_CYC - 16'd2) : (LOST_CYC - 16'd1);

  // Next-state and timer control; commands beat ID arrival, which beats line/stall events.
  always_comb begin
    state_d  = state_q;
    dest_d   = dest_q;
    lost_clr = 1'b0;
    lost_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        lost_clr = 1'b1;
        if (cmd_go) begin
          dest_d  = cmd[5:0];
          state_d = ST_FOLLOW;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FOLLOW, ST_LOST: begin
        if (cmd_stop) begin
          state_d  = ST_IDLE;
          lost_clr = 1'b1;
        end else if (cmd_go) begin
          dest_d = cmd[5:0];
        end else if (id_hit) begin
          state_d  = ST_IDLE;
          lost_clr = 1'b1;
        end else if (state_q == ST_FOLLOW) begin
          if (!line_present) begin
            state_d  = ST_LOST;
            lost_clr = 1'b1;
          end else if (moving) begin
            lost_clr = 1'b1;
          end else if (lost_tc) begin
            state_d  = ST_FAULT;
            lost_clr = 1'b1;
          end else begin
            lost_en = 1'b1;
          end
        end else begin
          if (line_present) begin
            state_d  = ST_FOLLOW;
            lost_clr = 1'b1;
          end else if (lost_tc) begin
            state_d  = ST_FAULT;
            lost_clr = 1'b1;
          end else begin
            lost_en = 1'b1;
          end
        end
      end
      ST_FAULT: begin
        lost_clr = 1'b1;
        if (cmd_stop) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        lost_clr = 1'b1;
      end
    endcase
  end

  assign buzz_en  = (state_q == ST_FAULT);
  assign buzz_clr = (state_q != ST_FAULT) || buzz_tc;

  // Outputs decoded from the next state so they move on the same edge as the state.
  always_comb begin
    go_d         = (state_d == ST_FOLLOW) || (state_d == ST_LOST);
    in_transit_d = go_d;
    if (state_d != ST_FAULT) begin
      buzz_d = 1'b0;
    end else if ((state_q == ST_FAULT) && buzz_tc) begin
      buzz_d = ~buzz_q;
    end else begin
      buzz_d = buzz_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      dest_q       <= 6'd0;
      go_q         <= 1'b0;
      in_transit_q <= 1'b0;
      buzz_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dest_q       <= dest_d;
      go_q         <= go_d;
      in_transit_q <= in_transit_d;
      buzz_q       <= buzz_d;
    end
  end

  follow_timer u_lost_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (lost_clr),
    .en    (lost_en),
    .term  (lost_term),
    .tc    (lost_tc)
  );

  follow_timer u_buzz_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (buzz_clr),
    .en    (buzz_en),
    .term  (BUZZ_DIV - 16'd1),
    .tc    (buzz_tc)
  );

  assign go         = go_q;
  assign in_transit = in_transit_q;
  assign buzz       = buzz_q;

endmodule
